// File: rtl/unpack64bit_pkg.sv
// Types and widths shared by the 64->16 unpacker and its 16->64 packer counterpart.
package unpack64bit_pkg;

  localparam int WORD_W = 16;
  localparam int WORDS  = 4;
  localparam int IDX_W  = $clog2(WORDS);

  typedef logic [IDX_W-1:0] word_idx_t;

  typedef enum logic {
    EMPTY = 1'b0,
    EMIT  = 1'b1
  } unpack_state_t;

endpackage

// File: rtl/unpack64bit.sv
// Splits each 64-bit MM2S beat into four 16-bit words, low word first, at one word per cycle.
//   state | meaning
//   EMPTY | no beat held, ready for a new one
//   EMIT  | beat held, presenting hold_data word selected by word_index
module unpack64bit
  import unpack64bit_pkg::*;
#(
  parameter int WORD_W = unpack64bit_pkg::WORD_W,
  parameter int WORDS  = unpack64bit_pkg::WORDS
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [WORD_W*WORDS-1:0] s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [WORD_W-1:0]       m_data,
  output logic                    m_valid,
  output logic                    m_last,
  input  logic                    m_ready,
  output word_idx_t               word_index,
  output logic                    busy
);

  localparam word_idx_t LAST_IDX = word_idx_t'(WORDS - 1);

  unpack_state_t             state, state_nxt;
  word_idx_t                 idx_nxt;
  logic [WORD_W*WORDS-1:0]   hold_data;
  logic                      hold_last;
  logic                      last_word;
  logic                      load;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= EMPTY;
      word_index <= '0;
      hold_data  <= '0;
      hold_last  <= 1'b0;
    end else begin
      state      <= state_nxt;
      word_index <= idx_nxt;
      if (load) begin
        hold_data <= s_data;
        hold_last <= s_last;
      end
    end
  end

  // s_ready looks straight through to m_ready so a new beat lands as the last word leaves.
  always_comb begin
    state_nxt = state;
    idx_nxt   = word_index;
    last_word = (word_index == LAST_IDX);
    s_ready   = aresetn && ((state == EMPTY) || (last_word && m_ready));
    load      = s_valid && s_ready;

    case (state)
      EMPTY: begin
        if (s_valid) state_nxt = EMIT;
      end
      EMIT: begin
        if (m_ready) begin
          if (!last_word) begin
            idx_nxt = word_index + word_idx_t'(1);
          end else if (!s_valid) begin
            state_nxt = EMPTY;
            idx_nxt   = '0;
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase

    if (load) idx_nxt = '0;
  end

  assign m_valid = (state == EMIT);
  assign busy    = (state == EMIT);
  assign m_data  = hold_data[WORD_W*int'(word_index) +: WORD_W];
  assign m_last  = hold_last && last_word && (state == EMIT);

endmodule

// File: tb/tb_unpack64bit.sv
// Directed checks of the 64->16 unpacker plus a packed round trip with random gaps.
module tb_unpack64bit;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic [1:0]  word_index;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 aclk = ~aclk;

  unpack64bit dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .word_index (word_index),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  logic [15:0] w1[4];
  logic [15:0] w3[8];
  logic [15:0] w5[4];

  localparam int NB = 16;
  localparam int NW = NB * 4;
  logic [15:0] rt_words[NW];
  logic [63:0] beats[NB];

  initial begin
    int bi, ri, cycles;
    logic fire_in;

    w1 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    w3 = '{16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'haaaa, 16'hbbbb, 16'hcccc};
    w5 = '{16'haaaa, 16'hbbbb, 16'hcccc, 16'hdddd};

    // reset and idle
    aresetn = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) begin
      cyc(); #1;
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_last", 64'(m_last), 64'd0);
      chk("rst_word_index", 64'(word_index), 64'd0);
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end
    aresetn = 1'b1; #1;
    chk("idle_s_ready", 64'(s_ready), 64'd1);
    chk("idle_m_valid", 64'(m_valid), 64'd0);

    // single beat
    s_data = 64'h4444_3333_2222_1111; s_last = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    cyc();
    s_valid = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("single_m_valid", 64'(m_valid), 64'd1);
      chk("single_m_data", 64'(m_data), 64'(w1[i]));
      chk("single_word_index", 64'(word_index), 64'(i));
      chk("single_m_last", 64'(m_last), 64'(i == 3));
      cyc(); #1;
    end
    chk("single_end_m_valid", 64'(m_valid), 64'd0);
    chk("single_end_busy", 64'(busy), 64'd0);

    // back-to-back beats
    s_data = 64'h8888_7777_6666_5555; s_last = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
    cyc();
    s_data = 64'hcccc_bbbb_aaaa_9999; s_last = 1'b1; #1;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_m_valid", 64'(m_valid), 64'd1);
      chk("b2b_m_data", 64'(m_data), 64'(w3[i]));
      chk("b2b_s_ready", 64'(s_ready), 64'((i % 4) == 3));
      chk("b2b_m_last", 64'(m_last), 64'(i == 7));
      cyc();
      if (i == 3) s_valid = 1'b0;
      #1;
    end
    chk("b2b_end_m_valid", 64'(m_valid), 64'd0);

    // back-pressure on word 1
    s_data = 64'h4444_3333_2222_1111; s_last = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
    cyc();
    s_valid = 1'b0; #1;
    chk("bp_w0", 64'(m_data), 64'h1111);
    cyc();
    m_ready = 1'b0; #1;
    repeat (5) begin
      chk("bp_stall_data", 64'(m_data), 64'h2222);
      chk("bp_stall_index", 64'(word_index), 64'd1);
      chk("bp_stall_s_ready", 64'(s_ready), 64'd0);
      chk("bp_stall_m_valid", 64'(m_valid), 64'd1);
      cyc(); #1;
    end
    m_ready = 1'b1; #1;
    chk("bp_w1", 64'(m_data), 64'h2222);
    cyc(); #1;
    chk("bp_w2", 64'(m_data), 64'h3333);
    cyc(); #1;
    chk("bp_w3", 64'(m_data), 64'h4444);
    chk("bp_w3_last", 64'(m_last), 64'd0);
    cyc(); #1;
    chk("bp_end_m_valid", 64'(m_valid), 64'd0);

    // reset mid-beat
    s_data = 64'h0004_0003_0002_0001; s_last = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    cyc();
    s_valid = 1'b0; #1;
    cyc(); #1;
    cyc(); #1;
    chk("mid_pre_index", 64'(word_index), 64'd2);
    chk("mid_pre_data", 64'(m_data), 64'h0003);
    aresetn = 1'b0;
    cyc(); #1;
    chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_index", 64'(word_index), 64'd0);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
    aresetn = 1'b1; s_data = 64'hdddd_cccc_bbbb_aaaa; s_last = 1'b0; s_valid = 1'b1;
    cyc();
    s_valid = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("mid_new_data", 64'(m_data), 64'(w5[i]));
      chk("mid_new_m_last", 64'(m_last), 64'd0);
      cyc(); #1;
    end
    chk("mid_end_m_valid", 64'(m_valid), 64'd0);

    // round trip: bench packs random words low-first, unpacker must restore the stream
    for (int i = 0; i < NW; i++) rt_words[i] = 16'($urandom);
    for (int b = 0; b < NB; b++)
      beats[b] = {rt_words[4*b+3], rt_words[4*b+2], rt_words[4*b+1], rt_words[4*b]};
    bi = 0; ri = 0; cycles = 0;
    s_valid = 1'b0; m_ready = 1'b0;
    while (ri < NW && cycles < 3000) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if (!s_valid && bi < NB && $urandom_range(0, 2) != 0) begin
        s_valid = 1'b1;
        s_data  = beats[bi];
        s_last  = (bi == NB - 1);
      end
      #1;
      fire_in = s_valid && s_ready;
      if (m_valid && m_ready) begin
        chk("rt_data", 64'(m_data), 64'(rt_words[ri]));
        chk("rt_last", 64'(m_last), 64'(ri == NW - 1));
        ri++;
      end
      cyc();
      cycles++;
      if (fire_in) begin
        bi++;
        s_valid = 1'b0;
      end
    end
    chk("rt_word_count", 64'(ri), 64'(NW));
    chk("rt_beat_count", 64'(bi), 64'(NB));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/unpack64bit.md
# unpack64bit

Unpacks each 64-bit beat from the MM2S FIFO into four 16-bit words for the 16-bit datapath (MUX/PE input side). It is the inverse of the 16→64 S2MM packer and uses the same word ordering: bits [15:0] go out first, bits [63:48] go out last. Both sides use valid/ready handshakes. Sustained throughput is one 16-bit word per cycle, with no bubble between consecutive 64-bit beats.

## Interface
Parameters:
- WORD_W, 16, output word width.
- WORDS, 4, words per input beat; input width is WORD_W*WORDS.

Ports:
- aclk, in, 1, clock.
- aresetn, in, 1, reset; synchronous, active-low.
- s_data, in, 64, packed beat from the MM2S FIFO.
- s_valid, in, 1, s_data valid.
- s_last, in, 1, beat is the last of a transfer.
- s_ready, out, 1, unpacker can accept a beat this cycle.
- m_data, out, 16, current unpacked word.
- m_valid, out, 1, m_data valid.
- m_last, out, 1, final word of the last beat.
- m_ready, in, 1, downstream accepts m_data.
- word_index, out, 2, index (0–3) of the word currently on m_data.
- busy, out, 1, a beat is held (state EMIT).

## Operation
- **Holding registers:** hold_data[63:0] and hold_last, loaded on s_valid && s_ready; word_index is set to 0 on the same load.
- **FSM states:**
  - EMPTY: nothing held. s_ready=1, m_valid=0.
  - EMIT: a beat is held. m_valid=1, m_data=hold_data[16*word_index +: 16].
- **Transitions:**
  - EMPTY → EMIT on s_valid.
  - In EMIT, on m_valid && m_ready && word_index<3: word_index increments and the state stays EMIT.
  - In EMIT, on m_ready && word_index==3 with s_valid=1: load the new beat, set word_index=0, stay in EMIT.
  - In EMIT, on m_ready && word_index==3 with s_valid=0: go to EMPTY.
- **s_ready** is combinational: (state==EMPTY) || (word_index==3 && m_ready). It depends combinationally on m_ready; this is intended so the block runs at full rate.
- **m_last** = hold_last && word_index==3 && state==EMIT.
- **busy** = (state==EMIT).
- **Stability:** while m_valid && !m_ready, m_data, m_last and word_index hold stable. word_index never wraps without a load or the move to EMPTY.
- **s_last handling:** no transfer-length checking. s_last only qualifies m_last.

## Timing
- Reset values (aresetn low): state EMPTY, word_index 0, hold_data 0, hold_last 0, m_valid 0, m_last 0, busy 0.
- s_ready is forced to 0 while aresetn is low and becomes 1 in the first cycle after reset release.
- Latency: a beat accepted at edge N presents word 0 with m_valid=1 in the cycle after edge N.
- Throughput: four consecutive words per beat with m_ready held high. When the last word is consumed and a new beat is accepted at the same edge, word 0 of the new beat appears in the next cycle with no bubble.
- A stall on any word delays only that word. No word is lost or repeated.
- Reset mid-beat: held words are discarded, and m_valid is 0 in the cycle after the reset edge.
- s_valid arriving in EMIT with word_index<3 is not accepted (s_ready=0). The upstream source must hold s_data.

## Structure
- Shared package:
  - WORD_W and WORDS constants, shared with the packer.
  - The 2-bit word-index type.
  - The unpacker state enum (EMPTY, EMIT).
- Single module, no sub-modules. The word select is an indexed part-select inside the module.

## Test plan
1. **Reset and idle:** hold aresetn low for 3 cycles, then release → m_valid=0, m_last=0, word_index=0 during reset; s_ready=1 on the first cycle after release.
2. **Single beat:** s_data=64'h4444_3333_2222_1111, s_last=1, m_ready=1 → m_data sequence 1111, 2222, 3333, 4444 on consecutive cycles; m_last=1 only with 4444; then EMPTY.
3. **Back-to-back beats:** two beats, s_valid held high, m_ready=1 → 8 words in 8 consecutive cycles; s_ready is high only in the word_index==3 cycles.
4. **Back-pressure:** drop m_ready for 5 cycles while word_index=1 → m_data=2222 stays stable and s_ready=0 throughout; the sequence then resumes with 3333.
5. **Reset mid-beat:** assert aresetn low at word_index=2 → m_valid=0 next cycle; a subsequent beat 64'hDDDD_CCCC_BBBB_AAAA emits AAAA first.
6. **Round trip:** random 16-bit stream through the packer, then this unpacker, with random m_ready/s_valid gaps → output stream equals input stream, and m_last coincides with the final word.
